// File: rtl/spi_flash_responder.sv
// SPI flash responder (mode 0): serves 0x03 reads from an internal byte array,
// plus 0xB9/0xAB power-down control. SPI pins are oversampled on CLK.
module spi_flash_responder #(
   parameter int          MEM_BYTES = 4096,
   parameter logic [23:0] BASE_ADDR = 24'h050000,
   parameter logic [7:0]  FILL_BYTE = 8'hFF,
   parameter bit          START_PD  = 1'b1
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic                         SPI_SCK,
   input  logic                         SPI_CS,
   input  logic                         SPI_SI,
   output logic                         SPI_SO,
   input  logic                         load_en,
   input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
   input  logic [7:0]                   load_data,
   output logic                         powered_down,
   output logic                         read_active,
   output logic [23:0]                  cur_addr
);

   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DATA, IGNORE
   } state_t;

   state_t state, state_n;

   logic [1:0] sck_s, cs_s, si_s;
   logic       sck_d, cs_d;
   logic       sck_rise, sck_fall, cs_fall, cs_rise, cs_hi, si;
   logic [4:0] bit_cnt;
   logic [6:0] cmd_sh;
   logic [7:0] cmd_byte;
   logic [7:0] data_sh;
   logic       pd_set, pd_clr;
   logic [23:0] addr_shift, fetch_addr, offset;
   logic [7:0] fetch_byte;

   logic [7:0] mem [MEM_BYTES];

   assign cs_hi    = cs_s[1];
   assign si       = si_s[1];
   assign sck_rise = sck_s[1] & ~sck_d;
   assign sck_fall = ~sck_s[1] & sck_d;
   assign cs_fall  = ~cs_s[1] & cs_d;
   assign cs_rise  = cs_s[1] & ~cs_d;

   assign cmd_byte    = {cmd_sh, si};
   assign addr_shift  = {cur_addr[22:0], si};
   assign read_active = (state == DATA);

   // The last address bit fetches the first byte; later fetches advance by one.
   always_comb begin
      fetch_addr = cur_addr + 24'd1;
      if (state == ADDR)
         fetch_addr = addr_shift;
      offset = fetch_addr - BASE_ADDR;
      fetch_byte = FILL_BYTE;
      if (offset < 24'(MEM_BYTES))
         fetch_byte = mem[offset[AW-1:0]];
   end

   always_comb begin
      state_n = state;
      if (cs_hi) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: if (cs_fall) state_n = CMD;
            CMD: begin
               if (sck_rise && bit_cnt == 5'd7) begin
                  state_n = IGNORE;
                  if (cmd_byte == 8'h03 && !powered_down)
                     state_n = ADDR;
               end
            end
            ADDR: if (sck_rise && bit_cnt == 5'd23) state_n = DATA;
            DATA: state_n = DATA;
            IGNORE: state_n = IGNORE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (load_en)
         mem[load_addr] <= load_data;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state        <= IDLE;
         sck_s        <= '0;
         cs_s         <= '0;
         si_s         <= '0;
         sck_d        <= 1'b0;
         cs_d         <= 1'b0;
         bit_cnt      <= '0;
         cmd_sh       <= '0;
         data_sh      <= '0;
         pd_set       <= 1'b0;
         pd_clr       <= 1'b0;
         SPI_SO       <= 1'b0;
         cur_addr     <= '0;
         powered_down <= START_PD;
      end else begin
         sck_s <= {sck_s[0], SPI_SCK};
         cs_s  <= {cs_s[0], SPI_CS};
         si_s  <= {si_s[0], SPI_SI};
         sck_d <= sck_s[1];
         cs_d  <= cs_s[1];
         state <= state_n;
         if (cs_hi) begin
            SPI_SO  <= 1'b0;
            bit_cnt <= '0;
            if (cs_rise) begin
               if (pd_set) powered_down <= 1'b1;
               if (pd_clr) powered_down <= 1'b0;
            end
            pd_set <= 1'b0;
            pd_clr <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  SPI_SO  <= 1'b0;
                  bit_cnt <= '0;
               end
               CMD: begin
                  if (sck_rise) begin
                     cmd_sh  <= cmd_byte[6:0];
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        pd_clr  <= (cmd_byte == 8'hAB);
                        pd_set  <= (cmd_byte == 8'hB9);
                     end
                  end
               end
               ADDR: begin
                  if (sck_rise) begin
                     cur_addr <= addr_shift;
                     bit_cnt  <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        data_sh <= fetch_byte;
                     end
                  end
               end
               DATA: begin
                  if (sck_fall) begin
                     SPI_SO  <= data_sh[7];
                     data_sh <= {data_sh[6:0], 1'b0};
                  end
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt  <= '0;
                        cur_addr <= cur_addr + 24'd1;
                        data_sh  <= fetch_byte;
                     end
                  end
               end
               default: SPI_SO <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: reads, power-down, range edges,
// aborted frames and reset during a transfer.
module tb_spi_flash_responder;

   localparam int HALF = 8;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        SPI_SCK = 1'b0;
   logic        SPI_CS = 1'b1;
   logic        SPI_SI = 1'b0;
   logic        SPI_SO;
   logic        load_en = 1'b0;
   logic [11:0] load_addr = '0;
   logic [7:0]  load_data = '0;
   logic        powered_down;
   logic        read_active;
   logic [23:0] cur_addr;

   int checks = 0;
   int failures = 0;

   spi_flash_responder #(
      .MEM_BYTES(4096),
      .BASE_ADDR(24'h050000),
      .FILL_BYTE(8'hFF),
      .START_PD(1'b1)
   ) dut (
      .CLK(CLK),
      .reset(reset),
      .SPI_SCK(SPI_SCK),
      .SPI_CS(SPI_CS),
      .SPI_SI(SPI_SI),
      .SPI_SO(SPI_SO),
      .load_en(load_en),
      .load_addr(load_addr),
      .load_data(load_data),
      .powered_down(powered_down),
      .read_active(read_active),
      .cur_addr(cur_addr)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [11:0] a, input logic [7:0] d);
      @(negedge CLK);
      load_en = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge CLK);
      load_en = 1'b0;
   endtask

   task automatic spi_bit(input logic b, output logic o);
      SPI_SI = b;
      repeat (HALF) @(negedge CLK);
      o = SPI_SO;
      SPI_SCK = 1'b1;
      repeat (HALF) @(negedge CLK);
      SPI_SCK = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic o;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], o);
         rx[i] = o;
      end
   endtask

   task automatic cs_low();
      SPI_CS = 1'b0;
      repeat (HALF) @(negedge CLK);
   endtask

   task automatic cs_high();
      SPI_CS = 1'b1;
      repeat (2 * HALF) @(negedge CLK);
   endtask

   task automatic read_start(input logic [23:0] a);
      logic [7:0] rx;
      cs_low();
      spi_byte(8'h03, rx);
      spi_byte(a[23:16], rx);
      spi_byte(a[15:8], rx);
      spi_byte(a[7:0], rx);
   endtask

   task automatic cmd_frame(input logic [7:0] op);
      logic [7:0] rx;
      cs_low();
      spi_byte(op, rx);
      cs_high();
   endtask

   logic [7:0] rx;
   logic       o;

   initial begin
      repeat (4) @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      chk("rst_so", SPI_SO, 0);
      chk("rst_ra", read_active, 0);
      chk("rst_addr", cur_addr, 0);
      chk("rst_pd", powered_down, 1);

      load(12'd0, 8'h11);
      load(12'd1, 8'h22);
      load(12'd2, 8'h33);
      load(12'd3, 8'h44);
      load(12'd4, 8'h0F);
      load(12'd4095, 8'hA5);

      read_start(24'h050000);
      chk("pd_ra", read_active, 0);
      spi_byte(8'h00, rx);
      chk("pd_read", rx, 8'h00);
      cs_high();

      cs_low();
      spi_byte(8'hAB, rx);
      chk("ab_pre_cs", powered_down, 1);
      cs_high();
      chk("ab_post_cs", powered_down, 0);

      read_start(24'h050000);
      chk("rd_ra", read_active, 1);
      spi_byte(8'h00, rx); chk("rd_b0", rx, 8'h11);
      spi_byte(8'h00, rx); chk("rd_b1", rx, 8'h22);
      spi_byte(8'h00, rx); chk("rd_b2", rx, 8'h33);
      spi_byte(8'h00, rx); chk("rd_b3", rx, 8'h44);
      chk("rd_addr", cur_addr, 24'h050004);
      cs_high();
      chk("rd_ra_end", read_active, 0);

      read_start(24'h050FFF);
      spi_byte(8'h00, rx); chk("top_b0", rx, 8'hA5);
      spi_byte(8'h00, rx); chk("top_b1", rx, 8'hFF);
      cs_high();

      read_start(24'hFFFFFF);
      spi_byte(8'h00, rx); chk("wrap_b0", rx, 8'hFF);
      chk("wrap_addr0", cur_addr, 24'h000000);
      spi_byte(8'h00, rx); chk("wrap_b1", rx, 8'hFF);
      chk("wrap_addr1", cur_addr, 24'h000001);
      cs_high();

      cs_low();
      spi_byte(8'h03, rx); chk("abort_so0", rx, 0);
      spi_byte(8'h05, rx); chk("abort_so1", rx, 0);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, o);
      cs_high();
      chk("abort_ra", read_active, 0);
      chk("abort_so2", SPI_SO, 0);
      read_start(24'h050001);
      spi_byte(8'h00, rx); chk("after_abort", rx, 8'h22);
      cs_high();

      cmd_frame(8'hB9);
      chk("b9_pd", powered_down, 1);
      cmd_frame(8'hAB);
      chk("b9_wake", powered_down, 0);

      read_start(24'h050004);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, o);
      SPI_SI = 1'b0;
      repeat (HALF) @(negedge CLK);
      chk("pre_rst_so", SPI_SO, 1);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      chk("mid_rst_so", SPI_SO, 0);
      chk("mid_rst_ra", read_active, 0);
      SPI_SCK = 1'b1;
      repeat (HALF) @(negedge CLK);
      SPI_SCK = 1'b0;
      for (int i = 0; i < 3; i++) spi_bit(1'b0, o);
      repeat (HALF) @(negedge CLK);
      chk("post_rst_so", SPI_SO, 0);
      chk("post_rst_ra", read_active, 0);
      cs_high();
      chk("post_rst_pd", powered_down, 1);
      cmd_frame(8'hAB);
      read_start(24'h050002);
      spi_byte(8'h00, rx); chk("post_rst_rd", rx, 8'h33);
      cs_high();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
